// File: rtl/finn_rtl_krnl_example_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the vadd_axis adder stream.
// A requester is granted for a whole packet; its adder constant is captured
// at grant time and presented alongside the stream. Packets longer than
// C_MAX_PKT_BEATS are cut with a forced tlast and a sticky error flag.
module finn_rtl_krnl_example_stream_arbiter #(
  parameter int C_NUM_REQ         = 4,
  parameter int C_TDATA_WIDTH     = 512,
  parameter int C_ADDER_BIT_WIDTH = 32,
  parameter int C_MAX_PKT_BEATS   = 256,
  parameter int C_ID_WIDTH        = 4
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [C_NUM_REQ-1:0]                   s_axis_tvalid,
  output logic [C_NUM_REQ-1:0]                   s_axis_tready,
  input  logic [C_NUM_REQ*C_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_NUM_REQ*C_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_NUM_REQ-1:0]                   s_axis_tlast,
  input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0] s_ctrl_constant,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [C_TDATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_TDATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                   m_axis_tlast,
  output logic [C_ID_WIDTH-1:0]                  m_axis_tid,
  output logic [C_ADDER_BIT_WIDTH-1:0]           m_ctrl_constant,
  output logic                                   busy,
  output logic [31:0]                            pkt_count,
  output logic                                   trunc_err
);

  localparam int KEEP_W    = C_TDATA_WIDTH / 8;
  localparam int CNT_W     = 16;
  localparam int PTR_EXT_W = C_ID_WIDTH + 1;
  localparam logic [CNT_W-1:0]     LAST_BEAT_IDX = CNT_W'(C_MAX_PKT_BEATS - 1);
  localparam logic [PTR_EXT_W-1:0] NUM_REQ_EXT   = PTR_EXT_W'(C_NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t                         state_reg, state_next;
  logic [C_ID_WIDTH-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [C_ID_WIDTH-1:0]          grant_reg, grant_next;
  logic [CNT_W-1:0]               beat_cnt_reg, beat_cnt_next;
  logic [C_ADDER_BIT_WIDTH-1:0]   constant_reg, constant_next;
  logic [31:0]                    pkt_count_reg, pkt_count_next;
  logic                           trunc_err_reg, trunc_err_next;

  // Per-requester views of the flattened input buses.
  logic [C_TDATA_WIDTH-1:0]       req_data  [C_NUM_REQ];
  logic [KEEP_W-1:0]              req_keep  [C_NUM_REQ];
  logic [C_ADDER_BIT_WIDTH-1:0]   req_const [C_NUM_REQ];

  // Granted-requester signals and arbitration results.
  logic [C_TDATA_WIDTH-1:0]       sel_data;
  logic [KEEP_W-1:0]              sel_keep;
  logic                           sel_valid;
  logic                           sel_last;
  logic [C_ADDER_BIT_WIDTH-1:0]   pick_const;
  logic [C_NUM_REQ-1:0]           tvalid_rot;
  logic [C_ID_WIDTH-1:0]          rr_pick;
  logic                           any_valid;
  logic                           forced_last;
  logic                           m_handshake;

  // (base + offs) mod C_NUM_REQ, valid for base, offs < C_NUM_REQ.
  function automatic logic [C_ID_WIDTH-1:0] wrap_add(
    input logic [C_ID_WIDTH-1:0] base,
    input logic [PTR_EXT_W-1:0]  offs
  );
    logic [PTR_EXT_W-1:0] sum;
    sum = {1'b0, base} + offs;
    if (sum >= NUM_REQ_EXT) begin
      sum = sum - NUM_REQ_EXT;
    end
    return sum[C_ID_WIDTH-1:0];
  endfunction

  generate
    for (genvar gi = 0; gi < C_NUM_REQ; gi++) begin : g_slice
      assign req_data[gi]  = s_axis_tdata[gi*C_TDATA_WIDTH +: C_TDATA_WIDTH];
      assign req_keep[gi]  = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
      assign req_const[gi] = s_ctrl_constant[gi*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH];
    end
  endgenerate

  // Round-robin search: rotate tvalid so rr_ptr lands at bit 0, lowest set bit wins.
  always_comb begin
    tvalid_rot = C_NUM_REQ'({s_axis_tvalid, s_axis_tvalid} >> rr_ptr_reg);
    any_valid  = |s_axis_tvalid;
    rr_pick    = rr_ptr_reg;
    for (int k = C_NUM_REQ - 1; k >= 0; k--) begin
      if (tvalid_rot[k]) begin
        rr_pick = wrap_add(rr_ptr_reg, PTR_EXT_W'(k));
      end
    end
  end

  // Select the granted requester's stream and the candidate's constant;
  // only the matching slice ever reaches the outputs.
  always_comb begin
    sel_data   = '0;
    sel_keep   = '0;
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    pick_const = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (grant_reg == C_ID_WIDTH'(i)) begin
        sel_data  = req_data[i];
        sel_keep  = req_keep[i];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
      if (rr_pick == C_ID_WIDTH'(i)) begin
        pick_const = req_const[i];
      end
    end
  end

  // Handshake pass-through: only the granted requester sees tready, only in XFER.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    if (state_reg == XFER) begin
      m_axis_tvalid = sel_valid;
      for (int i = 0; i < C_NUM_REQ; i++) begin
        if (grant_reg == C_ID_WIDTH'(i)) begin
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign forced_last     = (beat_cnt_reg == LAST_BEAT_IDX);
  assign m_handshake     = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata    = sel_data;
  assign m_axis_tkeep    = sel_keep;
  assign m_axis_tlast    = sel_last | forced_last;
  assign m_axis_tid      = grant_reg;
  assign m_ctrl_constant = constant_reg;
  assign busy            = (state_reg == XFER);
  assign pkt_count       = pkt_count_reg;
  assign trunc_err       = trunc_err_reg;

  // Next-state logic: grant in IDLE, count beats and close packets in XFER.
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    beat_cnt_next  = beat_cnt_reg;
    constant_next  = constant_reg;
    pkt_count_next = pkt_count_reg;
    trunc_err_next = trunc_err_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          grant_next    = rr_pick;
          constant_next = pick_const;
          beat_cnt_next = '0;
          state_next    = XFER;
        end
      end
      XFER: begin
        if (m_handshake) begin
          if (m_axis_tlast) begin
            // Remaining beats of a truncated packet will be re-arbitrated later.
            state_next     = IDLE;
            rr_ptr_next    = wrap_add(grant_reg, PTR_EXT_W'(1));
            beat_cnt_next  = '0;
            pkt_count_next = pkt_count_reg + 32'd1;
            if (forced_last && !sel_last) begin
              trunc_err_next = 1'b1;
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      beat_cnt_reg  <= '0;
      constant_reg  <= '0;
      pkt_count_reg <= '0;
      trunc_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      beat_cnt_reg  <= beat_cnt_next;
      constant_reg  <= constant_next;
      pkt_count_reg <= pkt_count_next;
      trunc_err_reg <= trunc_err_next;
    end
  end

endmodule

// File: tb/tb_finn_rtl_krnl_example_stream_arbiter.sv
// Scoreboard bench for the stream arbiter: tests push expected beats into a
// queue, requester drivers replay stored packets, a monitor checks each beat.
module tb_finn_rtl_krnl_example_stream_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int CW    = 32;
  localparam int MAXB  = 256;
  localparam int IDW   = 4;
  localparam int DEPTH = 1024;

  logic                 aclk = 1'b0;
  logic                 areset = 1'b1;
  logic [NREQ-1:0]      s_axis_tvalid;
  logic [NREQ-1:0]      s_axis_tready;
  logic [NREQ*DW-1:0]   s_axis_tdata;
  logic [NREQ*KW-1:0]   s_axis_tkeep;
  logic [NREQ-1:0]      s_axis_tlast;
  logic [NREQ*CW-1:0]   s_ctrl_constant;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [DW-1:0]        m_axis_tdata;
  logic [KW-1:0]        m_axis_tkeep;
  logic                 m_axis_tlast;
  logic [IDW-1:0]       m_axis_tid;
  logic [CW-1:0]        m_ctrl_constant;
  logic                 busy;
  logic [31:0]          pkt_count;
  logic                 trunc_err;

  finn_rtl_krnl_example_stream_arbiter #(
    .C_NUM_REQ(NREQ), .C_TDATA_WIDTH(DW), .C_ADDER_BIT_WIDTH(CW),
    .C_MAX_PKT_BEATS(MAXB), .C_ID_WIDTH(IDW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_ctrl_constant(s_ctrl_constant),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_ctrl_constant(m_ctrl_constant), .busy(busy),
    .pkt_count(pkt_count), .trunc_err(trunc_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0]  data;
    logic           last;
    logic [IDW-1:0] tid;
    logic [CW-1:0]  cst;
  } exp_t;

  exp_t          exp_q[$];
  int            hs_cycles[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            beat_no = 0;
  bit            bp_random = 1'b0;

  logic [DW-1:0] st_data [NREQ][DEPTH];
  logic          st_last [NREQ][DEPTH];
  int            head [NREQ];
  int            tail [NREQ];

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mkdata(input int r, input int p, input int b);
    return {8'(r + 1), 8'(p), 16'(b)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic load_pkt(input int r, input int p, input int n);
    for (int b = 1; b <= n; b++) begin
      st_data[r][tail[r]] = mkdata(r, p, b);
      st_last[r][tail[r]] = (b == n);
      tail[r]++;
    end
  endtask

  task automatic expect_range(input int r, input int p, input int first, input int last_b,
                              input bit last_flag, input logic [CW-1:0] cst);
    exp_t e;
    for (int b = first; b <= last_b; b++) begin
      e.data = mkdata(r, p, b);
      e.last = last_flag && (b == last_b);
      e.tid  = IDW'(r);
      e.cst  = cst;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_const(input int r, input logic [CW-1:0] v);
    s_ctrl_constant[r*CW +: CW] = v;
  endtask

  task automatic sync();
    @(negedge aclk);
    #2;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge aclk);
      n++;
    end
    repeat (2) @(negedge aclk);
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: got %0d beats still pending, required 0", name, exp_q.size());
    end
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("%s_store%0d_empty", name, i), 64'(tail[i] - head[i]), 64'd0);
    end
  endtask

  // Assert reset asynchronously and verify every output clears at once.
  task automatic assert_reset();
    areset = 1'b1;
    for (int i = 0; i < NREQ; i++) head[i] = tail[i];
    #1;
    check("reset_s_tready",  64'(s_axis_tready), 64'd0);
    check("reset_m_tvalid",  64'(m_axis_tvalid), 64'd0);
    check("reset_busy",      64'(busy), 64'd0);
    check("reset_pkt_count", 64'(pkt_count), 64'd0);
    check("reset_trunc_err", 64'(trunc_err), 64'd0);
    check("reset_ctrl_const", 64'(m_ctrl_constant), 64'd0);
    check("reset_tid",       64'(m_axis_tid), 64'd0);
  endtask

  task automatic do_reset();
    sync();
    exp_q.delete();
    assert_reset();
    repeat (2) @(negedge aclk);
    #2 areset = 1'b0;
  endtask

  // Requester drivers and downstream ready: drive on negedge, sample handshakes just before posedge.
  initial begin
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge aclk);
      for (int i = 0; i < NREQ; i++) begin
        if (head[i] < tail[i]) begin
          s_axis_tvalid[i]           = 1'b1;
          s_axis_tdata[i*DW +: DW]   = st_data[i][head[i]];
          s_axis_tkeep[i*KW +: KW]   = st_data[i][head[i]][KW-1:0];
          s_axis_tlast[i]            = st_last[i][head[i]];
        end else begin
          s_axis_tvalid[i] = 1'b0;
          s_axis_tlast[i]  = 1'b0;
        end
      end
      m_axis_tready = bp_random ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      for (int i = 0; i < NREQ; i++) begin
        if (s_axis_tvalid[i] && s_axis_tready[i]) head[i]++;
      end
    end
  end

  // Monitor: every output handshake pops one expected beat and compares it.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      #4;
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cycles.push_back(cyc);
        beat_no++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat%0d_unexpected: got data=%h tid=%0d, required no beat",
                   beat_no, m_axis_tdata, m_axis_tid);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.data || m_axis_tkeep !== e.data[KW-1:0] ||
              m_axis_tlast !== e.last || m_axis_tid !== e.tid || m_ctrl_constant !== e.cst) begin
            failures++;
            $display("FAIL beat%0d: got data=%h keep=%h last=%b tid=%0d cst=%h, required data=%h keep=%h last=%b tid=%0d cst=%h",
                     beat_no, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_ctrl_constant,
                     e.data, e.data[KW-1:0], e.last, e.tid, e.cst);
          end else begin
            $display("beat%0d cyc=%0d tid=%0d data=%h last=%b cst=%h ok",
                     beat_no, cyc, m_axis_tid, m_axis_tdata, m_axis_tlast, m_ctrl_constant);
          end
        end
        check($sformatf("beat%0d_tready_onehot", beat_no), 64'(s_axis_tready),
              64'(NREQ'(1) << m_axis_tid));
      end
    end
  end

  // Directed test sequence.
  initial begin
    int base;
    int n;
    s_ctrl_constant = '0;

    // T1: requesters 0 and 2, two 4-beat packets each, full throughput.
    do_reset();
    set_const(0, 32'hA0);
    set_const(2, 32'hA2);
    expect_range(0, 0, 1, 4, 1'b1, 32'hA0);
    expect_range(2, 0, 1, 4, 1'b1, 32'hA2);
    expect_range(0, 1, 1, 4, 1'b1, 32'hA0);
    expect_range(2, 1, 1, 4, 1'b1, 32'hA2);
    hs_cycles.delete();
    load_pkt(0, 0, 4); load_pkt(0, 1, 4);
    load_pkt(2, 0, 4); load_pkt(2, 1, 4);
    drain("t1", 200);
    check("t1_beats", 64'(hs_cycles.size()), 64'd16);
    if (hs_cycles.size() == 16)
      check("t1_span_cycles", 64'(hs_cycles[15] - hs_cycles[0]), 64'd18);
    check("t1_pkt_count", 64'(pkt_count), 64'd4);

    // T2: all four requesters, 1-beat packets, strict rotation 0,1,2,3,0,...
    do_reset();
    for (int r = 0; r < NREQ; r++) set_const(r, 32'(32'h11 * (r + 1)));
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NREQ; r++) expect_range(r, p, 1, 1, 1'b1, 32'(32'h11 * (r + 1)));
    hs_cycles.delete();
    for (int r = 0; r < NREQ; r++) begin
      load_pkt(r, 0, 1);
      load_pkt(r, 1, 1);
    end
    drain("t2", 200);
    check("t2_beats", 64'(hs_cycles.size()), 64'd8);
    if (hs_cycles.size() == 8)
      for (int i = 0; i < 7; i++)
        check($sformatf("t2_gap%0d", i), 64'(hs_cycles[i+1] - hs_cycles[i]), 64'd2);
    check("t2_pkt_count", 64'(pkt_count), 64'd8);

    // T3: constant changes mid-packet are ignored until the next grant.
    sync();
    set_const(1, 32'h5);
    expect_range(1, 0, 1, 4, 1'b1, 32'h5);
    expect_range(1, 1, 1, 4, 1'b1, 32'h7);
    load_pkt(1, 0, 4);
    load_pkt(1, 1, 4);
    n = 0;
    while (!busy && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("t3_grant_seen", 64'(busy), 64'd1);
    repeat (2) @(negedge aclk);
    #2 set_const(1, 32'h7);
    #1 check("t3_const_held", 64'(m_ctrl_constant), 64'h5);
    drain("t3", 200);
    check("t3_const_after", 64'(m_ctrl_constant), 64'h7);
    check("t3_tid_held", 64'(m_axis_tid), 64'd1);
    check("t3_pkt_count", 64'(pkt_count), 64'd10);

    // T4: 300-beat packet truncated at 256; tail arrives as its own packet.
    do_reset();
    set_const(0, 32'h1234);
    expect_range(0, 0, 1, MAXB, 1'b1, 32'h1234);
    expect_range(0, 0, MAXB + 1, 300, 1'b1, 32'h1234);
    load_pkt(0, 0, 300);
    drain("t4", 2000);
    check("t4_trunc_err", 64'(trunc_err), 64'd1);
    check("t4_pkt_count", 64'(pkt_count), 64'd2);

    // T5: requesters 0,1,3 under random backpressure; rr_ptr is 1 after T4.
    begin
      int lens [3][3];
      int ids [3];
      lens = '{'{3, 1, 5}, '{2, 4, 1}, '{5, 2, 3}};
      ids  = '{0, 1, 3};
      sync();
      for (int j = 0; j < 3; j++) set_const(ids[j], 32'(32'h100 + ids[j]));
      for (int p = 0; p < 3; p++) begin
        expect_range(1, p, 1, lens[1][p], 1'b1, 32'h101);
        expect_range(3, p, 1, lens[2][p], 1'b1, 32'h103);
        expect_range(0, p, 1, lens[0][p], 1'b1, 32'h100);
      end
      bp_random = 1'b1;
      for (int j = 0; j < 3; j++)
        for (int p = 0; p < 3; p++) load_pkt(ids[j], p, lens[j][p]);
      drain("t5", 2000);
      bp_random = 1'b0;
      check("t5_pkt_count", 64'(pkt_count), 64'd11);
      check("t5_trunc_err_sticky", 64'(trunc_err), 64'd1);
    end

    // T6: reset mid-packet at beat 3 of 8, then arbitration restarts from 0.
    sync();
    expect_range(1, 5, 1, 1, 1'b1, 32'h101);
    load_pkt(1, 5, 1);
    drain("t6_pre", 200);
    sync();
    set_const(2, 32'h202);
    expect_range(2, 0, 1, 3, 1'b0, 32'h202);
    base = hs_cycles.size();
    load_pkt(2, 0, 8);
    n = 0;
    while (hs_cycles.size() < base + 3 && n < 200) begin
      @(posedge aclk);
      n++;
    end
    check("t6_reached_beat3", 64'(hs_cycles.size() - base), 64'd3);
    #1;
    check("t6_m_tvalid_before_reset", 64'(m_axis_tvalid), 64'd1);
    check("t6_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    assert_reset();
    repeat (2) @(negedge aclk);
    #2 areset = 1'b0;
    #1;
    check("t6_pkt_count_after", 64'(pkt_count), 64'd0);
    check("t6_trunc_err_after", 64'(trunc_err), 64'd0);
    sync();
    set_const(0, 32'h300);
    expect_range(0, 7, 1, 2, 1'b1, 32'h300);
    expect_range(2, 7, 1, 2, 1'b1, 32'h202);
    load_pkt(0, 7, 2);
    load_pkt(2, 7, 2);
    drain("t6", 200);
    check("t6_pkt_count", 64'(pkt_count), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
